ws2812_frame_scheduler: RTL

//  Sequences a chain of WS2812 LEDs. Holds a NUM_LEDS x 24-bit pixel buffer written by the host.
//  On start, streams pixels 0..NUM_LEDS-1 to the single-pixel serializer over a valid/ready

---
 rtl/ws2812_frame_scheduler_if.sv | 27 ++
 rtl/ws2812_frame_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ws2812_frame_scheduler_if.sv
// Host / serializer side signals of the WS2812 frame scheduler.
// The scheduler connects through the slave modport; the host side
// (pixel writer plus serializer handshake) uses the master modport.
interface ws2812_frame_scheduler_if #(
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              start;
   logic [23:0]       pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              latch_active;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data, start, pix_ready,
      input  pix_data, pix_valid, latch_active, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, pix_ready,
      output pix_data, pix_valid, latch_active, busy, done
   );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame scheduler: holds a NUM_LEDS x 24-bit pixel buffer, streams
// pixels 0..NUM_LEDS-1 to the serializer over valid/ready, then holds the
// line low for TRESET cycles so the chain latches the frame.
module ws2812_frame_scheduler #(
   parameter int NUM_LEDS = 8,
   parameter int ADDR_W   = 3,
   parameter int TRESET   = 2560
) (
   input logic                     CLK,
   input logic                     RST,
   ws2812_frame_scheduler_if.slave bus
);
   localparam int                CNT_W      = $clog2(TRESET);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(TRESET - 1);
   localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] index_reg, index_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              pending_reg, pending_next;
   logic              done_reg, done_next;

   // Buffer is sized to the full address space so every address is a legal
   // index; entries at or beyond NUM_LEDS are simply never written or read.
   logic [23:0]       mem [2**ADDR_W];
   logic [23:0]       rd_data_reg;
   logic              wr_ok;

   assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_LEDS_W);

   // Pixel buffer: write port plus registered read; a read and write of the
   // same address in one cycle returns the old contents.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
      if (state_reg == FETCH) begin
         rd_data_reg <= mem[index_reg];
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= IDLE;
         index_reg   <= '0;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         index_reg   <= index_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         done_reg    <= done_next;
      end
   end

   // Next-state logic: frame sequencing, latch timing, start merging.
   always_comb begin
      state_next   = state_reg;
      index_next   = index_reg;
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      done_next    = 1'b0;

      // A start that arrives mid-frame is remembered; repeats collapse.
      if (bus.start && (state_reg != IDLE)) begin
         pending_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = FETCH;
               index_next = '0;
            end
         end
         FETCH: begin
            state_next = SEND;
         end
         SEND: begin
            if (bus.pix_ready) begin
               if (index_reg == LAST_IDX) begin
                  state_next = LATCH;
                  cnt_next   = '0;
               end else begin
                  state_next = FETCH;
                  index_next = index_reg + 1'b1;
               end
            end
         end
         LATCH: begin
            if (cnt_reg == LAST_CNT) begin
               done_next = 1'b1;
               // A start landing on the final latch cycle counts as pending.
               if (pending_reg || bus.start) begin
                  state_next   = FETCH;
                  index_next   = '0;
                  pending_next = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decode straight from registered state, so reset clears them at once.
   assign bus.pix_valid    = (state_reg == SEND);
   assign bus.latch_active = (state_reg == LATCH);
   assign bus.busy         = (state_reg != IDLE);
   assign bus.done         = done_reg;
   assign bus.pix_data     = (state_reg == SEND) ? rd_data_reg : 24'h0;

endmodule
